// File: rtl/glyph_stroke_seq_if.sv
// Segment bus from the stroke sequencer to the line-drawing / motion controller.
interface glyph_stroke_seq_if #(
  parameter int OUT_W = 11
);
  logic             seg_valid;
  logic             seg_ready;
  logic [OUT_W-1:0] seg_sx;
  logic [OUT_W-1:0] seg_sy;
  logic [OUT_W-1:0] seg_ex;
  logic [OUT_W-1:0] seg_ey;
  logic             seg_pen;
  logic             seg_clip;

  modport master (
    output seg_valid, seg_sx, seg_sy, seg_ex, seg_ey, seg_pen, seg_clip,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_sx, seg_sy, seg_ex, seg_ey, seg_pen, seg_clip,
    output seg_ready
  );
endinterface

// File: rtl/glyph_stroke_seq.sv
// Stroke sequencer: walks the combinational stroke table for one glyph,
// scales/offsets each stroke into plotter space and hands segments
// downstream one at a time over valid/ready.
module glyph_stroke_seq #(
  parameter int COORD_W     = 8,
  parameter int IDX_W       = 5,
  parameter int GLYPH_W     = 4,
  parameter int MAX_STROKES = 32,
  parameter int OUT_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [GLYPH_W-1:0] glyph,
  input  logic [OUT_W-1:0]   origin_x,
  input  logic [OUT_W-1:0]   origin_y,
  input  logic [1:0]         scale,
  input  logic               skip_travel,
  output logic [GLYPH_W-1:0] glyph_sel,
  output logic [IDX_W-1:0]   stroke_idx,
  input  logic [COORD_W-1:0] tbl_sx,
  input  logic [COORD_W-1:0] tbl_sy,
  input  logic [COORD_W-1:0] tbl_ex,
  input  logic [COORD_W-1:0] tbl_ey,
  input  logic               tbl_pen,
  glyph_stroke_seq_if.master seg,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int SUM_W = OUT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_STROKES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t           state;
  logic [OUT_W-1:0] org_x, org_y;
  logic [1:0]       scale_r;
  logic             skip_r;
  logic             term_r, cap_r;

  logic [SUM_W-1:0] sum_sx, sum_sy, sum_ex, sum_ey;
  logic [OUT_W-1:0] sat_sx, sat_sy, sat_ex, sat_ey;
  logic             clip_any, term_now, cap_now;

  // origin + (coord << shift), one spare bit to detect overflow
  function automatic logic [SUM_W-1:0] place(input logic [OUT_W-1:0]   org,
                                             input logic [COORD_W-1:0] c,
                                             input logic [1:0]         sh);
    logic [SUM_W-1:0] ce;
    ce = SUM_W'(c) << sh;
    return {1'b0, org} + ce;
  endfunction

  // Transform and saturate the current table entry; classify it
  always_comb begin
    sum_sx   = place(org_x, tbl_sx, scale_r);
    sum_sy   = place(org_y, tbl_sy, scale_r);
    sum_ex   = place(org_x, tbl_ex, scale_r);
    sum_ey   = place(org_y, tbl_ey, scale_r);
    sat_sx   = sum_sx[OUT_W] ? '1 : sum_sx[OUT_W-1:0];
    sat_sy   = sum_sy[OUT_W] ? '1 : sum_sy[OUT_W-1:0];
    sat_ex   = sum_ex[OUT_W] ? '1 : sum_ex[OUT_W-1:0];
    sat_ey   = sum_ey[OUT_W] ? '1 : sum_ey[OUT_W-1:0];
    clip_any = sum_sx[OUT_W] | sum_sy[OUT_W] | sum_ex[OUT_W] | sum_ey[OUT_W];
    term_now = !tbl_pen && (tbl_ex == '0) && (tbl_ey == '0);
    cap_now  = (stroke_idx == LAST_IDX);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      glyph_sel     <= '0;
      stroke_idx    <= '0;
      org_x         <= '0;
      org_y         <= '0;
      scale_r       <= '0;
      skip_r        <= 1'b0;
      term_r        <= 1'b0;
      cap_r         <= 1'b0;
      seg.seg_valid <= 1'b0;
      seg.seg_sx    <= '0;
      seg.seg_sy    <= '0;
      seg.seg_ex    <= '0;
      seg.seg_ey    <= '0;
      seg.seg_pen   <= 1'b0;
      seg.seg_clip  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        seg.seg_valid <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              glyph_sel  <= glyph;
              org_x      <= origin_x;
              org_y      <= origin_y;
              scale_r    <= scale;
              skip_r     <= skip_travel;
              stroke_idx <= '0;
              busy       <= 1'b1;
              state      <= FETCH;
            end
          end
          FETCH: begin
            seg.seg_sx   <= sat_sx;
            seg.seg_sy   <= sat_sy;
            seg.seg_ex   <= sat_ex;
            seg.seg_ey   <= sat_ey;
            seg.seg_pen  <= tbl_pen;
            seg.seg_clip <= clip_any;
            term_r       <= term_now;
            cap_r        <= cap_now;
            if (term_now && skip_r) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              seg.seg_valid <= 1'b1;
              state         <= ISSUE;
            end
          end
          ISSUE: begin
            if (seg.seg_ready) begin
              seg.seg_valid <= 1'b0;
              if (term_r || cap_r) begin
                // overrun is asserted alongside done rather than held as a pending flag
                done    <= 1'b1;
                overrun <= cap_r && !term_r;
                state   <= DONE;
              end else begin
                stroke_idx <= stroke_idx + 1'b1;
                state      <= FETCH;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glyph_stroke_seq.sv
// Directed bench for glyph_stroke_seq: digit-9 placement/scale, clipping,
// terminal-first glyph, ready stalls, stroke cap overrun, abort and reset.
module tb_glyph_stroke_seq;

  typedef struct packed {
    logic [10:0] sx, sy, ex, ey;
    logic        pen, clip;
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // stroke table: {sx, sy, ex, ey, pen}
  function automatic logic [32:0] tbl(input logic [3:0] g, input logic [4:0] i);
    logic [7:0] ii;
    ii = {3'b000, i};
    case (g)
      4'd9: case (i)
        5'd0: return {8'd0,   8'd0,   8'd120, 8'd120, 1'b0};
        5'd1: return {8'd120, 8'd120, 8'd120, 8'd40,  1'b1};
        5'd2: return {8'd120, 8'd40,  8'd30,  8'd40,  1'b1};
        5'd3: return {8'd30,  8'd120, 8'd30,  8'd40,  1'b1};
        5'd4: return {8'd30,  8'd40,  8'd120, 8'd120, 1'b1};
        5'd5: return {8'd180, 8'd120, 8'd0,   8'd0,   1'b0};
        default: return '0;
      endcase
      4'd1: return {8'd10, 8'd20, 8'd0, 8'd0, 1'b0};
      4'd2: return {ii, ii + 8'd1, ii + 8'd5, ii + 8'd7, 1'b1};
      default: return '0;
    endcase
  endfunction

  function automatic seg_t mk(input logic [10:0] sx, sy, ex, ey, input logic pen, clip);
    return {sx, sy, ex, ey, pen, clip};
  endfunction

  // DUT A: default cap
  logic        a_start = 0, a_abort = 0, a_skip = 0;
  logic [3:0]  a_glyph = '0, a_gsel;
  logic [10:0] a_ox = '0, a_oy = '0;
  logic [1:0]  a_scale = '0;
  logic [4:0]  a_idx;
  logic [7:0]  a_tsx, a_tsy, a_tex, a_tey;
  logic        a_tpen, a_busy, a_done, a_ovr;
  glyph_stroke_seq_if #(.OUT_W(11)) sa ();
  assign {a_tsx, a_tsy, a_tex, a_tey, a_tpen} = tbl(a_gsel, a_idx);

  glyph_stroke_seq #(.COORD_W(8), .IDX_W(5), .GLYPH_W(4), .MAX_STROKES(32), .OUT_W(11)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .glyph(a_glyph),
    .origin_x(a_ox), .origin_y(a_oy), .scale(a_scale), .skip_travel(a_skip),
    .glyph_sel(a_gsel), .stroke_idx(a_idx),
    .tbl_sx(a_tsx), .tbl_sy(a_tsy), .tbl_ex(a_tex), .tbl_ey(a_tey), .tbl_pen(a_tpen),
    .seg(sa.master), .busy(a_busy), .done(a_done), .overrun(a_ovr)
  );

  // DUT B: cap of 4 strokes
  logic        b_start = 0;
  logic [3:0]  b_gsel;
  logic [4:0]  b_idx;
  logic [7:0]  b_tsx, b_tsy, b_tex, b_tey;
  logic        b_tpen, b_busy, b_done, b_ovr;
  glyph_stroke_seq_if #(.OUT_W(11)) sb ();
  assign {b_tsx, b_tsy, b_tex, b_tey, b_tpen} = tbl(b_gsel, b_idx);
  assign sb.seg_ready = 1'b1;

  glyph_stroke_seq #(.COORD_W(8), .IDX_W(5), .GLYPH_W(4), .MAX_STROKES(4), .OUT_W(11)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(1'b0), .glyph(4'd2),
    .origin_x(11'd0), .origin_y(11'd0), .scale(2'd0), .skip_travel(1'b0),
    .glyph_sel(b_gsel), .stroke_idx(b_idx),
    .tbl_sx(b_tsx), .tbl_sy(b_tsy), .tbl_ex(b_tex), .tbl_ey(b_tey), .tbl_pen(b_tpen),
    .seg(sb.master), .busy(b_busy), .done(b_done), .overrun(b_ovr)
  );

  logic a_ready = 1'b1;
  assign sa.seg_ready = a_ready;
  logic stall_en = 1'b0;

  // monitors, sampled on the falling edge
  seg_t qa[$], qb[$];
  int a_done_cnt = 0, a_done_cyc = 0, a_ovr_cnt = 0;
  int b_done_cnt = 0, b_done_cyc = 0, b_ovr_cnt = 0, b_ovr_cyc = 0;
  seg_t prev_seg;
  logic pv = 0, pr = 0;

  always @(negedge clk) begin
    seg_t cur;
    cur = {sa.seg_sx, sa.seg_sy, sa.seg_ex, sa.seg_ey, sa.seg_pen, sa.seg_clip};
    if (rst) begin
      pv = 0;
    end else begin
      if (sa.seg_valid && pv && !pr) check("hold", cur, prev_seg);
      if (sa.seg_valid && sa.seg_ready) qa.push_back(cur);
      if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
      if (a_ovr) a_ovr_cnt++;
      pv = sa.seg_valid; pr = sa.seg_ready; prev_seg = cur;
      if (sb.seg_valid) qb.push_back({sb.seg_sx, sb.seg_sy, sb.seg_ex, sb.seg_ey, sb.seg_pen, sb.seg_clip});
      if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
      if (b_ovr) begin b_ovr_cnt++; b_ovr_cyc = cyc; end
    end
  end

  function automatic seg_t qa_at(input int k);
    return (k < qa.size()) ? qa[k] : seg_t'('0);
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (stall_en) a_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic start_a(input logic [3:0] g, input logic [10:0] ox, oy,
                         input logic [1:0] sc, input logic sk, output int t0);
    step();
    qa.delete();
    a_glyph = g; a_ox = ox; a_oy = oy; a_scale = sc; a_skip = sk;
    a_start = 1'b1; t0 = cyc;
    step();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int base);
    int n;
    n = 0;
    while (a_done_cnt == base && n < 300) begin step(); n++; end
    if (a_done_cnt == base) check("done_timeout", 0, 1);
  endtask

  initial begin
    int t0, base;
    #2;
    check("rst_valid", sa.seg_valid, 0);
    check("rst_seg", {sa.seg_sx, sa.seg_sy, sa.seg_ex, sa.seg_ey, sa.seg_pen, sa.seg_clip}, 0);
    check("rst_ctl", {a_busy, a_done, a_ovr, a_gsel, a_idx}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // digit 9, scale 0
    base = a_done_cnt;
    start_a(4'd9, 11'd100, 11'd50, 2'd0, 1'b0, t0);
    check("busy_t1", a_busy, 1);
    wait_done_a(base);
    check("n9_cnt", qa.size(), 6);
    check("n9_s0", qa_at(0), mk(100, 50, 220, 170, 0, 0));
    check("n9_s1", qa_at(1), mk(220, 170, 220, 90, 1, 0));
    check("n9_s5", qa_at(5), mk(280, 170, 100, 50, 0, 0));
    check("n9_done_cyc", a_done_cyc, t0 + 13);
    check("n9_busy_after", a_busy, 0);

    // digit 9, scale 1
    base = a_done_cnt;
    start_a(4'd9, 11'd100, 11'd50, 2'd1, 1'b0, t0);
    wait_done_a(base);
    check("s1_cnt", qa.size(), 6);
    check("s1_s0", qa_at(0), mk(100, 50, 340, 290, 0, 0));

    // digit 9, scale 1, skip travel, random ready stalls
    stall_en = 1'b1;
    base = a_done_cnt;
    start_a(4'd9, 11'd100, 11'd50, 2'd1, 1'b1, t0);
    wait_done_a(base);
    stall_en = 1'b0; a_ready = 1'b1;
    check("sk_cnt", qa.size(), 5);
    check("sk_s0", qa_at(0), mk(100, 50, 340, 290, 0, 0));
    check("sk_s1", qa_at(1), mk(340, 290, 340, 130, 1, 0));
    check("sk_s2", qa_at(2), mk(340, 130, 160, 130, 1, 0));
    check("sk_s3", qa_at(3), mk(160, 290, 160, 130, 1, 0));
    check("sk_s4", qa_at(4), mk(160, 130, 340, 290, 1, 0));

    // clipping: origin_x near full scale, scale x8
    base = a_done_cnt;
    start_a(4'd9, 11'd2000, 11'd50, 2'd3, 1'b1, t0);
    wait_done_a(base);
    check("clip_s0", qa_at(0), mk(2000, 50, 2047, 1010, 0, 1));

    // terminal stroke 0
    base = a_done_cnt;
    start_a(4'd1, 11'd100, 11'd50, 2'd0, 1'b0, t0);
    wait_done_a(base);
    check("t0_cnt", qa.size(), 1);
    check("t0_s0", qa_at(0), mk(110, 70, 100, 50, 0, 0));
    check("t0_done_cyc", a_done_cyc, t0 + 3);
    base = a_done_cnt;
    start_a(4'd1, 11'd100, 11'd50, 2'd0, 1'b1, t0);
    wait_done_a(base);
    check("t0sk_cnt", qa.size(), 0);
    check("t0sk_done_cyc", a_done_cyc, t0 + 2);
    check("a_no_ovr", a_ovr_cnt, 0);

    // stroke cap on DUT B
    step();
    qb.delete();
    b_start = 1'b1; t0 = cyc;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 40 && b_done_cnt == 0; i++) step();
    check("cap_cnt", qb.size(), 4);
    check("cap_s3", (qb.size() > 3) ? qb[3] : seg_t'('0), mk(3, 4, 8, 10, 1, 0));
    check("cap_done_cyc", b_done_cyc, t0 + 9);
    check("cap_ovr_cyc", b_ovr_cyc, t0 + 9);
    check("cap_ovr_cnt", b_ovr_cnt, 1);

    // abort during stroke 2 issue
    base = a_done_cnt;
    start_a(4'd9, 11'd100, 11'd50, 2'd0, 1'b0, t0);
    for (int i = 0; i < 20 && cyc < t0 + 6; i++) step();
    check("ab_idx", a_idx, 2);
    check("ab_valid_pre", sa.seg_valid, 1);
    a_ready = 1'b0; a_abort = 1'b1;
    step();
    a_abort = 1'b0; a_ready = 1'b1;
    check("ab_valid_post", sa.seg_valid, 0);
    check("ab_busy", a_busy, 0);
    for (int i = 0; i < 5; i++) step();
    check("ab_no_done", a_done_cnt, base);
    check("ab_cnt", qa.size(), 2);

    // start and abort together in idle
    a_start = 1'b1; a_abort = 1'b1;
    step();
    a_start = 1'b0; a_abort = 1'b0;
    check("sa_idle", a_busy, 0);

    // asynchronous reset mid-fetch
    start_a(4'd9, 11'd100, 11'd50, 2'd0, 1'b0, t0);
    for (int i = 0; i < 20 && cyc < t0 + 3; i++) step();
    check("rf_sx_pre", sa.seg_sx, 100);
    rst = 1'b1;
    #1;
    check("rf_seg", {sa.seg_valid, sa.seg_sx, sa.seg_sy, sa.seg_ex, sa.seg_ey, sa.seg_pen, sa.seg_clip}, 0);
    check("rf_ctl", {a_busy, a_done, a_ovr, a_gsel, a_idx}, 0);
    step();
    rst = 1'b0;
    step();
    check("rf_idle", a_busy, 0);
    base = a_done_cnt;
    start_a(4'd1, 11'd0, 11'd0, 2'd0, 1'b1, t0);
    wait_done_a(base);
    check("rf_resume", a_done_cyc, t0 + 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
